// File: rtl/fetch_sequencer.sv
// fetch_sequencer: 4004-style fetch front end (PC, microcycle counter, address/instruction bus phases).
// Optional two-word fetch enabled by defining FETCH_TWO_WORD_EN.
module fetch_sequencer #(
  parameter int DATA_W       = 4,
  parameter int ADDR_NIBBLES = 3,
  parameter int CYCLE_LEN    = 8,
  parameter int RESET_PC     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           jump_valid,
  input  logic [DATA_W*ADDR_NIBBLES-1:0] jump_addr,
  input  logic [DATA_W-1:0]              bus_in,
  output logic [DATA_W-1:0]              bus_out,
  output logic                           bus_oe,
  output logic                           sync,
  output logic [2:0]                     cycle,
  output logic [DATA_W-1:0]              opr,
  output logic [DATA_W-1:0]              opa,
  output logic                           instr_valid,
  output logic                           second_word,
  output logic [DATA_W-1:0]              opr2,
  output logic [DATA_W-1:0]              opa2,
  output logic [DATA_W*ADDR_NIBBLES-1:0] pc
);
  localparam int PW = DATA_W * ADDR_NIBBLES;
  localparam int CW = ($clog2(CYCLE_LEN) < 3) ? 3 : $clog2(CYCLE_LEN);
  localparam logic [CW-1:0] LAST = CW'(CYCLE_LEN - 1);
  localparam logic [CW-1:0] AN   = CW'(ADDR_NIBBLES);
  localparam logic [CW-1:0] M1   = CW'(ADDR_NIBBLES);
  localparam logic [CW-1:0] M2   = CW'(ADDR_NIBBLES + 1);

  if (CYCLE_LEN < ADDR_NIBBLES + 2) begin : g_len_check
    $error("fetch_sequencer: CYCLE_LEN must be >= ADDR_NIBBLES+2");
  end

  logic [CW-1:0] cnt, nxt, idx;
  logic [PW-1:0] addr, pc_nxt, src;
  logic          run, last, pend;

  // run is clear only between reset and the first clock that enters cycle 0
  always_comb begin
    last   = cnt == LAST;
    nxt    = last ? '0 : cnt + 1'b1;
    idx    = run ? nxt : '0;
    pc_nxt = (jump_valid && !pend) ? jump_addr : pc + 1'b1;
    src    = !run ? pc : (last ? pc_nxt : addr);
  end

  assign cycle       = cnt[2:0];
  assign instr_valid = last && !stall && !pend;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      run     <= 1'b0;
      pc      <= PW'(RESET_PC);
      addr    <= PW'(RESET_PC);
      bus_out <= '0;
      bus_oe  <= 1'b0;
      sync    <= 1'b0;
    end else if (!stall) begin
      run    <= 1'b1;
      bus_oe <= idx < AN;
      sync   <= idx == '0;
      if (run) cnt <= nxt;
      if (run && last) pc <= pc_nxt;
      if (!run || last) addr <= src;
      if (idx < AN) bus_out <= DATA_W'(src >> (DATA_W * idx));
    end

`ifdef FETCH_TWO_WORD_EN
  logic                sw;
  logic [DATA_W-1:0]   opr2_r, opa2_r;
  assign pend = !sw && (opr == DATA_W'(1) || (opr == DATA_W'(2) && !opa[0]) ||
                        opr == DATA_W'(4) || opr == DATA_W'(5) || opr == DATA_W'(7));
  assign second_word = sw;
  assign opr2        = opr2_r;
  assign opa2        = opa2_r;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      opr    <= '0;
      opa    <= '0;
      opr2_r <= '0;
      opa2_r <= '0;
      sw     <= 1'b0;
    end else if (!stall && run) begin
      if (cnt == M1 && !sw) opr <= bus_in;
      if (cnt == M2 && !sw) opa <= bus_in;
      if (cnt == M1 && sw) opr2_r <= bus_in;
      if (cnt == M2 && sw) opa2_r <= bus_in;
      if (last) sw <= pend;
    end
`else
  assign pend        = 1'b0;
  assign second_word = 1'b0;
  assign opr2        = '0;
  assign opa2        = '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      opr <= '0;
      opa <= '0;
    end else if (!stall && run) begin
      if (cnt == M1) opr <= bus_in;
      if (cnt == M2) opa <= bus_in;
    end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed + randomized bench with a microcycle-level reference model.
module tb_fetch_sequencer;
  localparam int AN = 3, CL = 8;
  logic        clk = 1'b0, rst, stall, jump_valid;
  logic [11:0] jump_addr, pc, cap;
  logic [3:0]  bus_in, bus_out, opr, opa, opr2, opa2;
  logic        bus_oe, sync, instr_valid, second_word;
  logic [2:0]  cycle;
  logic [7:0]  rom [4096];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .sync(sync), .cycle(cycle),
    .opr(opr), .opa(opa), .instr_valid(instr_valid), .second_word(second_word),
    .opr2(opr2), .opa2(opa2), .pc(pc)
  );

  // ROM model: address assembled from the driven nibbles, data returned in M1/M2
  always @(posedge clk) if (bus_oe) cap[cycle*4 +: 4] <= bus_out;
  assign bus_in = cycle == 3 ? rom[cap][7:4] : cycle == 4 ? rom[cap][3:0] : cap[3:0] ^ {1'b0, cycle};

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic bit two(input logic [7:0] w);
`ifdef FETCH_TWO_WORD_EN
    return (w[7:4] inside {4'd1, 4'd4, 4'd5, 4'd7}) || (w[7:4] == 4'd2 && !w[4-4]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] nib(input logic [11:0] a, input int i);
    return 4'(a >> (4 * i));
  endfunction

  // reference model: one fetch address per microcycle, clock index k inside it
  bit         m_pre, m_sw, aw;
  int         m_k;
  logic [11:0] m_fa;
  logic [3:0] l_opr, l_opa, l_opr2, l_opa2;
  logic [7:0] mw, cw;

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_pre = 1; m_k = 0; m_fa = 0; m_sw = 0;
      l_opr = 0; l_opa = 0; l_opr2 = 0; l_opa2 = 0;
    end else if (!stall) begin
      if (m_pre) m_pre = 0;
      else if (m_k == CL - 1) begin
        mw = rom[m_fa];
        aw = !m_sw && two(mw);
        if (m_sw) {l_opr2, l_opa2} = mw;
        else {l_opr, l_opa} = mw;
        m_fa = (jump_valid && !aw) ? jump_addr : m_fa + 12'd1;
        m_sw = aw;
        m_k = 0;
      end else m_k++;
    end

  always @(negedge clk) begin
    cw = rom[m_fa];
    chk("cycle", cycle, m_k);
    chk("pc", pc, m_fa);
    chk("sync", sync, !m_pre && m_k == 0);
    chk("bus_oe", bus_oe, !m_pre && m_k < AN);
    chk("bus_out", bus_out, m_pre ? 4'd0 : nib(m_fa, m_k < AN ? m_k : AN - 1));
    chk("opr", opr, (!m_sw && m_k > AN) ? cw[7:4] : l_opr);
    chk("opa", opa, (!m_sw && m_k > AN + 1) ? cw[3:0] : l_opa);
    chk("instr_valid", instr_valid, !m_pre && m_k == CL - 1 && !stall && !(!m_sw && two(cw)));
    chk("second_word", second_word, m_sw);
    chk("opr2", opr2, (m_sw && m_k > AN) ? cw[7:4] : l_opr2);
    chk("opa2", opa2, (m_sw && m_k > AN + 1) ? cw[3:0] : l_opa2);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cycle != c && n < 40) begin tick; n++; end
    if (cycle != c) chk("wait_timeout", cycle, c);
  endtask

  initial begin
    logic [11:0] e;
    int n;
    foreach (rom[i]) rom[i] = 8'($urandom);
    rom[12'h000] = 8'hD5; rom[12'h001] = 8'hD0; rom[12'hFFF] = 8'hD0;
    rom[12'h3A7] = 8'hD0; rom[12'h3A8] = 8'hD0; rom[12'h123] = 8'hD0;
    rom[12'h010] = 8'h42; rom[12'h011] = 8'h8F;
    rst = 1; stall = 0; jump_valid = 0; jump_addr = 0;
    repeat (2) tick;
    chk("rst_cycle", cycle, 0); chk("rst_pc", pc, 0); chk("rst_oe", bus_oe, 0);
    chk("rst_sync", sync, 0); chk("rst_iv", instr_valid, 0); chk("rst_opr", opr, 0);
    rst = 0;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("a0_cycle", cycle, i); chk("a0_bus", bus_out, 0); chk("a0_oe", bus_oe, 1);
      tick;
    end
    repeat (2) tick;
    chk("first_opr", opr, 4'hD); chk("first_opa", opa, 4'h5);
    repeat (2) tick;
    chk("first_iv_cycle", cycle, 7); chk("first_iv", instr_valid, 1);
    tick;
    chk("pc_inc", pc, 12'h001);
    wait_cyc(7); jump_valid = 1; jump_addr = 12'hFFF; tick; jump_valid = 0;
    for (int i = 0; i < 3; i++) begin chk("fff_bus", bus_out, 4'hF); tick; end
    wait_cyc(7); tick;
    chk("pc_wrap", pc, 12'h000);
    wait_cyc(7); jump_valid = 1; jump_addr = 12'h3A7; tick; jump_valid = 0;
    chk("jump_pc", pc, 12'h3A7);
    e = 12'h3A7;
    for (int i = 0; i < 3; i++) begin chk("jump_bus", bus_out, e[i*4 +: 4]); tick; end
    jump_valid = 1; jump_addr = 12'h555; tick; jump_valid = 0;
    wait_cyc(7); tick;
    chk("jump_ignored_pc", pc, 12'h3A8);
    wait_cyc(4); stall = 1;
    repeat (5) begin
      tick;
      chk("stall_cycle", cycle, 4); chk("stall_iv", instr_valid, 0); chk("stall_opr", opr, 4'hD);
    end
    stall = 0; n = 0;
    while (!instr_valid && n < 20) begin tick; n++; end
    chk("stall_delay", n, 3);
    tick;
    chk("stall_no_dup", instr_valid, 0); chk("stall_pc", pc, 12'h3A9);
    wait_cyc(7); jump_valid = 1; jump_addr = 12'h123; tick; jump_valid = 0;
    wait_cyc(5);
    chk("pre_rst_pc", pc, 12'h123);
    rst = 1; #1;
    chk("arst_cycle", cycle, 0); chk("arst_pc", pc, 0); chk("arst_oe", bus_oe, 0);
    chk("arst_opr", opr, 0); chk("arst_sync", sync, 0);
    tick; rst = 0; tick;
    chk("restart_pc", pc, 0); chk("restart_oe", bus_oe, 1); chk("restart_sync", sync, 1);
`ifdef FETCH_TWO_WORD_EN
    wait_cyc(7); jump_valid = 1; jump_addr = 12'h010; tick; jump_valid = 0;
    wait_cyc(7);
    chk("tw_first_iv", instr_valid, 0);
    tick;
    chk("tw_sw", second_word, 1); chk("tw_pc1", pc, 12'h011);
    wait_cyc(7);
    chk("tw_iv", instr_valid, 1); chk("tw_opr", opr, 4'h4); chk("tw_opa", opa, 4'h2);
    chk("tw_opr2", opr2, 4'h8); chk("tw_opa2", opa2, 4'hF);
    tick;
    chk("tw_pc2", pc, 12'h012); chk("tw_sw_clr", second_word, 0);
`endif
    repeat (3000) begin
      stall = ($urandom % 5) == 0;
      jump_valid = ($urandom % 3) == 0;
      jump_addr = 12'($urandom);
      rst = ($urandom % 400) == 0;
      tick;
    end
    rst = 0; stall = 0; jump_valid = 0;
    repeat (4) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised instruction-fetch front end for the 4004-style CPU.
- Owns the program counter and the microcycle counter.
- Drives the multiplexed address nibbles onto the external bus during the A-phases, then latches the OPR/OPA instruction nibbles during the M-phases.
- Presents a decoded-ready instruction to the execute stage. Supports stall, and supports jump load at the instruction boundary.

Parameters:
- DATA_W, 4: bus and nibble width in bits.
- ADDR_NIBBLES, 3: number of address nibbles. PC width = DATA_W*ADDR_NIBBLES.
- CYCLE_LEN, 8: microcycle length in clocks. Must be >= ADDR_NIBBLES+2; elaboration-time error otherwise.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  freeze sequencer and all state while high
- jump_valid  in  1  load jump_addr as next PC at end of current microcycle
- jump_addr  in  DATA_W*ADDR_NIBBLES  jump target
- bus_in  in  DATA_W  ROM data nibble
- bus_out  out  DATA_W  address nibble driven to bus
- bus_oe  out  1  bus_out valid/drive enable
- sync  out  1  high during cycle 0 (start of microcycle)
- cycle  out  3  current microcycle index
- opr  out  DATA_W  latched upper instruction nibble
- opa  out  DATA_W  latched lower instruction nibble
- instr_valid  out  1  one-clock pulse: opr/opa hold a complete instruction
- second_word  out  1  current microcycle fetches the 2nd word of a 2-word instruction
- opr2  out  DATA_W  2nd-word upper nibble
- opa2  out  DATA_W  2nd-word lower nibble
- pc  out  DATA_W*ADDR_NIBBLES  current program counter

Reset:
- rst is asynchronous and active-high; clk is the clock. All state is updated on posedge clk.
- On reset: cycle=0, pc=RESET_PC, bus_out=0, bus_oe=0, sync=0, opr=opa=opr2=opa2=0, instr_valid=0, second_word=0.

Behaviour:
- Microcycle counter:
  - Increments 0..CYCLE_LEN-1, then wraps to 0.
  - Held when stall=1.
  - Only the low 3 bits are exported on `cycle`.
- sync is a registered output: high exactly while cycle==0.
- Address snapshot: on entry to cycle 0, pc is copied into an internal addr latch. A-phases drive from this latch, so a PC change mid-cycle never tears the address.
- A-phases, cycle k for k=0..ADDR_NIBBLES-1:
  - bus_out = addr nibble k, low nibble first.
  - bus_oe = 1.
- M1, cycle ADDR_NIBBLES: bus_oe=0; bus_in is sampled into opr (or opr2 if second_word).
- M2, cycle ADDR_NIBBLES+1: bus_oe=0; bus_in is sampled into opa (or opa2 if second_word).
- X-phases, remaining cycles: bus_oe=0, bus_out holds its last value.
- Last cycle (CYCLE_LEN-1):
  - instr_valid pulses for 1 clock, unless the instruction is awaiting its 2nd word.
  - PC update: if jump_valid, pc <= jump_addr; else pc <= pc+1, modulo 2^(DATA_W*ADDR_NIBBLES). FFF wraps to 000.
- jump_valid is sampled only on the last cycle and ignored on other cycles. A jump and an increment in the same cycle: jump wins.
- stall:
  - Freezes cycle, pc, the latches and bus outputs. Outputs hold.
  - instr_valid is forced 0 while stalled and re-emitted on the first unstalled last-cycle clock.
- Reset mid-microcycle: immediate return to reset values. The next fetch starts at cycle 0 with RESET_PC.

Optional Feature:
- Macro: FETCH_TWO_WORD_EN.
- Defined:
  - After M2, if {opr,opa} is a 2-word opcode, the next microcycle sets second_word=1. The 2-word opcodes are: opr 1 (JCN), 2 with opa[0]=0 (FIM), 4 (JUN), 5 (JMS), 7 (ISZ).
  - No instr_valid pulse occurs in the first microcycle. The PC increments normally.
  - The second microcycle fetches opr2/opa2. instr_valid pulses at its end with opr/opa unchanged. second_word then clears.
  - A jump_valid in the first word's last cycle is ignored.
- Undefined: second_word, opr2 and opa2 are tied to 0, and every microcycle is a single-word fetch.

Test Plan:
- Reset release, default params, ROM returns opr=D, opa=5 at pc 000:
  - bus_out 0,0,0 on cycles 0-2 with bus_oe=1.
  - opr=D and opa=5 after cycle 4.
  - instr_valid at cycle 7, then pc=001.
- Free run to pc=FFF: next microcycle drives address nibbles F,F,F; after the last cycle pc=000.
- jump_valid=1 with jump_addr=3A7 during cycle 7: next A-phases drive 7,A,3; jump_valid pulsed on cycle 3 is ignored.
- stall high for 5 clocks during cycle 4:
  - cycle, pc and opr frozen.
  - instr_valid is delayed exactly 5 clocks; no duplicate pulse.
- rst asserted at cycle 5 with pc=123: outputs go to reset values immediately; fetch restarts at 000.
- FETCH_TWO_WORD_EN defined, ROM at 010 holds 4,2 and at 011 holds 8,F:
  - No instr_valid after the first microcycle.
  - second_word=1 in the second microcycle, with opr2=8 and opa2=F.
  - Single instr_valid with opr=4, opa=2; pc=012.
